// File: rtl/ud_count_monitor.sv
// ---------------------------------------------------------------------------
// ud_count_monitor
//   Receive-side checker for an up/down counter. Watches the count bus,
//   recovers the counting direction, declares lock after LOCK_N consecutive
//   same-direction single steps, and flags reversals and illegal jumps.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   q_in       observed count value (WIDTH bits)
//   sample_en  q_in is valid this cycle and is evaluated
//   dir        decoded direction, 1 = up, 0 = down
//   locked     direction confirmed
//   rev        one-cycle pulse when a locked direction reverses
//   err        one-cycle pulse on an illegal jump (glitch or skipped code)
//   step_cnt   in-direction steps seen while locked (wraps, kept across relock)
// ---------------------------------------------------------------------------
module ud_count_monitor #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 3,   // legal range 1..15
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  q_in,
   input  logic              sample_en,
   output logic              dir,
   output logic              locked,
   output logic              rev,
   output logic              err,
   output logic [STEP_W-1:0] step_cnt
);

   typedef enum logic [1:0] {S_INIT, S_SEEK, S_LOCK} state_e;

   localparam logic [3:0]       LOCK_V = 4'(LOCK_N);
   localparam logic [WIDTH-1:0] D_UP   = WIDTH'(1);
   localparam logic [WIDTH-1:0] D_DN   = {WIDTH{1'b1}};

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    prev_q,  prev_d;
   logic [3:0]          run_q,   run_d;
   logic                cand_q,  cand_d;
   logic                dir_q,   dir_d;
   logic                locked_q, locked_d;
   logic                rev_q,   rev_d;
   logic                err_q,   err_d;
   logic [STEP_W-1:0]   step_q,  step_d;

   // Step classification; modular subtraction makes both wraps single steps.
   logic [WIDTH-1:0] delta;
   logic             is_up, is_dn, is_step, is_hold, step_dir;
   logic [3:0]       run_n;

   assign delta    = q_in - prev_q;
   assign is_up    = (delta == D_UP);
   assign is_dn    = (delta == D_DN);
   assign is_step  = is_up | is_dn;
   assign is_hold  = (delta == '0);
   assign step_dir = is_up;

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so
      // no path through the case leaves a signal unassigned (no latches).
      state_d  = state_q;
      prev_d   = prev_q;
      run_d    = run_q;
      cand_d   = cand_q;
      dir_d    = dir_q;
      locked_d = locked_q;
      step_d   = step_q;
      rev_d    = 1'b0;
      err_d    = 1'b0;
      run_n    = run_q;

      if (sample_en) begin
         prev_d = q_in;
         unique case (state_q)
            S_INIT: state_d = S_SEEK;   // first sample only primes prev

            S_SEEK: begin
               if (is_step) begin
                  if ((step_dir == cand_q) && (run_q != 4'd0)) begin
                     run_n = (run_q >= LOCK_V) ? LOCK_V : run_q + 4'd1;
                  end else begin
                     cand_d = step_dir;
                     run_n  = 4'd1;
                  end
                  run_d = run_n;
                  if (run_n == LOCK_V) begin
                     state_d  = S_LOCK;
                     dir_d    = step_dir;
                     locked_d = 1'b1;
                  end
               end else if (!is_hold) begin
                  run_d = 4'd0;
                  err_d = 1'b1;
               end
            end

            S_LOCK: begin
               if (is_step) begin
                  if (step_dir == dir_q) begin
                     step_d = step_q + STEP_W'(1);
                  end else begin
                     rev_d  = 1'b1;
                     cand_d = step_dir;
                     run_d  = 4'd1;
                     // A single step is already enough to relock.
                     if (LOCK_V == 4'd1) begin
                        dir_d = step_dir;
                     end else begin
                        locked_d = 1'b0;
                        state_d  = S_SEEK;
                     end
                  end
               end else if (!is_hold) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  run_d    = 4'd0;
                  state_d  = S_SEEK;   // dir keeps its last value
               end
            end

            default: state_d = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q  <= S_INIT;
         prev_q   <= '0;
         run_q    <= '0;
         cand_q   <= 1'b0;
         dir_q    <= 1'b0;
         locked_q <= 1'b0;
         rev_q    <= 1'b0;
         err_q    <= 1'b0;
         step_q   <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         run_q    <= run_d;
         cand_q   <= cand_d;
         dir_q    <= dir_d;
         locked_q <= locked_d;
         rev_q    <= rev_d;
         err_q    <= err_d;
         step_q   <= step_d;
      end
   end

   assign dir      = dir_q;
   assign locked   = locked_q;
   assign rev      = rev_q;
   assign err      = err_q;
   assign step_cnt = step_q;

endmodule
